// File: rtl/alu_op_scheduler_pkg.sv
// Shared types for the ALU operation scheduler.
//   operation_t   : 3-bit operation code carried on req_op0/req_op1
//   sched_state_t : scheduler FSM state, also exported on dbg_state
//   NUM_REQ       : number of requesters sharing the ALU
package operation_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_MUL     = 3'b010,
    OP_DIV     = 3'b011,
    OP_AND     = 3'b100,
    OP_OR      = 3'b101,
    OP_XOR     = 3'b110,
    OP_INVALID = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    DIVIDE = 2'd2,
    RESP   = 2'd3
  } sched_state_t;

  localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Request/response bundle between the requesters, the scheduler and the
// result consumer.
//   req_valid/req_ready : per-requester command handshake (bit i = requester i)
//   req_op*/req_a*/req_b*: command payload of requester 0 and 1
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_data/rsp_err : result payload
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high; the source holds valid and its
// payload unchanged until that edge, and ready never waits on anything
// the source does after asserting valid.
interface alu_op_scheduler_if
  import operation_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [2:0]         req_op0;
  logic [2:0]         req_op1;
  logic [DATA_W-1:0]  req_a0;
  logic [DATA_W-1:0]  req_b0;
  logic [DATA_W-1:0]  req_a1;
  logic [DATA_W-1:0]  req_b1;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_op_scheduler_seq_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per cycle.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load dividend/divisor (pulse, only while not busy)
//   dividend, divisor : operands sampled on start
//   busy         : iterations outstanding
//   done         : high in the cycle whose edge performs the last iteration
//   quotient     : quotient after the current iteration; final when done
// Exactly DATA_W iterations follow a start. The caller registers quotient
// on the edge where done is high, so no extra cycle is spent copying it.
module seq_divider
  import operation_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;   // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0] r_div;

  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_fits;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;

  // Bring down the next dividend bit and try the subtraction; a clear
  // borrow bit means the divisor fits and the quotient bit is 1.
  assign w_shift   = {r_rem, r_quo[DATA_W-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_fits    = ~w_diff[DATA_W];
  assign w_rem_nxt = w_fits ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign w_quo_nxt = {r_quo[DATA_W-2:0], w_fits};

  assign busy     = (r_cnt != '0);
  assign done     = (r_cnt == CNT_W'(1));
  assign quotient = w_quo_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (start) begin
      r_cnt <= CNT_W'(DATA_W);
      r_rem <= '0;
      r_quo <= dividend;
      r_div <= divisor;
    end else if (busy) begin
      r_cnt <= r_cnt - 1'b1;
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Two-requester ALU front end: round-robin arbitration, one command in
// flight, single-cycle ALU ops and a multi-cycle divider.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : alu_op_scheduler_if.slave (commands in, results out)
//   dbg_state    : current scheduler state
module alu_op_scheduler
  import operation_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_op_scheduler_if.slave   bus,
  output sched_state_t        dbg_state
);

  sched_state_t      r_state;
  logic              r_prio;      // requester favoured when both are valid
  operation_t        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_id;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_id;
  logic              r_rsp_err;

  logic               w_gnt_id;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_xfer;
  operation_t         w_op_in;
  logic [DATA_W-1:0]  w_a_in;
  logic [DATA_W-1:0]  w_b_in;
  logic               w_div_start;
  logic               w_div_busy;
  logic               w_div_done;
  logic [DATA_W-1:0]  w_div_quo;
  logic [DATA_W-1:0]  w_result;
  logic               w_err;

  always_comb begin
    w_gnt_id = 1'b0;
    case (bus.req_valid)
      2'b10:   w_gnt_id = 1'b1;
      2'b11:   w_gnt_id = r_prio;
      default: w_gnt_id = 1'b0;
    endcase
  end

  // reset_n gates ready so nothing is offered while reset is held.
  assign w_req_ready = (reset_n && (r_state == IDLE) && (bus.req_valid != '0))
                     ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign w_xfer      = |(bus.req_valid & w_req_ready);

  assign w_op_in     = operation_t'(w_gnt_id ? bus.req_op1 : bus.req_op0);
  assign w_a_in      = w_gnt_id ? bus.req_a1 : bus.req_a0;
  assign w_b_in      = w_gnt_id ? bus.req_b1 : bus.req_b0;
  // A zero divisor never reaches the divider; EXEC reports it instead.
  assign w_div_start = w_xfer && (w_op_in == OP_DIV) && (w_b_in != '0);

  seq_divider #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (w_div_start),
    .dividend (w_a_in),
    .divisor  (w_b_in),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_div_quo)
  );

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_op)
      OP_ADD: w_result = r_a + r_b;
      OP_SUB: w_result = r_a - r_b;
      OP_MUL: w_result = r_a * r_b;
      OP_AND: w_result = r_a & r_b;
      OP_OR:  w_result = r_a | r_b;
      OP_XOR: w_result = r_a ^ r_b;
      OP_DIV: begin            // only the divide-by-zero case executes here
        w_result = '1;
        w_err    = 1'b1;
      end
      default: begin           // OP_INVALID
        w_result = '0;
        w_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_op    <= w_op_in;
            r_a     <= w_a_in;
            r_b     <= w_b_in;
            r_id    <= w_gnt_id;
            r_prio  <= ~w_gnt_id;
            r_state <= w_div_start ? DIVIDE : EXEC;
          end
        end
        EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_result;
          r_rsp_err   <= w_err;
          r_rsp_id    <= r_id;
          r_state     <= RESP;
        end
        DIVIDE: begin
          if (w_div_busy && w_div_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_div_quo;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= r_id;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_err   = r_rsp_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed scenarios plus a random phase, all
// responses checked against an arithmetic reference model and a
// round-robin grant model.
module tb_alu_op_scheduler;
  import operation_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk     = 1'b0;
  logic         reset_n = 1'b1;
  sched_state_t dbg_state;

  always #5 clk = ~clk;

  alu_op_scheduler_if #(.DATA_W(W)) bus ();

  alu_op_scheduler #(.DATA_W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int unsigned ua, ub, md, r;
    logic e;
    ua = a; ub = b; md = 1 << W; e = 1'b0; r = 0;
    case (op)
      3'd0: r = (ua + ub) % md;
      3'd1: r = (ua + md - ub) % md;
      3'd2: r = (ua * ub) % md;
      3'd3: if (ub == 0) begin r = md - 1; e = 1'b1; end else r = ua / ub;
      3'd4: r = ua & ub;
      3'd5: r = ua | ub;
      3'd6: r = ua ^ ub;
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, r[W-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  logic         exp_id_q[$];
  int           exp_lat_q[$];
  int           cyc = 0;
  int           xfer_cyc = 0;
  int           xfer_count[2];
  bit           busy_m = 1'b0;
  bit           seen_m = 1'b0;
  logic         last_id = 1'b1;
  logic [W-1:0] hold_data;
  logic         hold_id;
  logic         hold_err;

  task automatic pop_exp();
    void'(exp_q.pop_front());
    void'(exp_err_q.pop_front());
    void'(exp_id_q.pop_front());
    void'(exp_lat_q.pop_front());
    busy_m = 1'b0;
    seen_m = 1'b0;
  endtask

  task automatic monitor();
    logic [1:0]   exp_g;
    logic [1:0]   xfer;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W:0]   res;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete(); exp_err_q.delete(); exp_id_q.delete(); exp_lat_q.delete();
        busy_m = 1'b0; seen_m = 1'b0; last_id = 1'b1;
      end else begin
        cyc++;
        if (busy_m) begin
          // One command in flight: nobody may be granted, including the
          // cycle in which the result handshake completes.
          check_eq("ready_while_busy", bus.req_ready, 2'b00);
          if (bus.rsp_valid) begin
            if (!seen_m) begin
              check_eq("rsp_latency", cyc - xfer_cyc, exp_lat_q[0]);
              check_eq("rsp_id", bus.rsp_id, exp_id_q[0]);
              check_eq("rsp_data", bus.rsp_data, exp_q[0]);
              check_eq("rsp_err", bus.rsp_err, exp_err_q[0]);
              hold_data = bus.rsp_data; hold_id = bus.rsp_id; hold_err = bus.rsp_err;
              seen_m = 1'b1;
            end else begin
              check_eq("hold_data", bus.rsp_data, hold_data);
              check_eq("hold_id", bus.rsp_id, hold_id);
              check_eq("hold_err", bus.rsp_err, hold_err);
            end
            if (bus.rsp_ready) pop_exp();
          end else if (seen_m) begin
            check_eq("rsp_valid_drop", bus.rsp_valid, 1'b1);
            pop_exp();
          end else if (cyc - xfer_cyc > W + 4) begin
            check_eq("rsp_timeout", bus.rsp_valid, 1'b1);
            pop_exp();
          end
        end else begin
          check_eq("spurious_rsp_valid", bus.rsp_valid, 1'b0);
          case (bus.req_valid)
            2'b01:   exp_g = 2'b01;
            2'b10:   exp_g = 2'b10;
            2'b11:   exp_g = last_id ? 2'b01 : 2'b10;
            default: exp_g = 2'b00;
          endcase
          check_eq("grant", bus.req_ready, exp_g);
          xfer = bus.req_valid & bus.req_ready;
          if (xfer != 2'b00) begin
            if (xfer[1]) begin op = bus.req_op1; a = bus.req_a1; b = bus.req_b1; end
            else         begin op = bus.req_op0; a = bus.req_a0; b = bus.req_b0; end
            res = ref_result(op, a, b);
            exp_q.push_back(res[W-1:0]);
            exp_err_q.push_back(res[W]);
            exp_id_q.push_back(xfer[1]);
            exp_lat_q.push_back((op == 3'd3 && b != 0) ? W + 1 : 2);
            xfer_count[xfer[1]]++;
            last_id  = xfer[1];
            busy_m   = 1'b1;
            seen_m   = 1'b0;
            xfer_cyc = cyc;
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  int drv_seen[2];
  bit rand_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (xfer_count[i] != drv_seen[i]) begin
        drv_seen[i] = xfer_count[i];
        bus.req_valid[i] = 1'b0;
      end
    end
    if (rand_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic offer(input int i, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    if (i == 0) begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
    else        begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((bus.req_valid != 2'b00 || busy_m) && k < 400) begin
      step();
      k++;
    end
    check_eq("drain_done", {30'd0, bus.req_valid != 2'b00, busy_m}, 32'd0);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = 2'b11;
    bus.req_op0 = 3'd0; bus.req_a0 = '0; bus.req_b0 = '0;
    bus.req_op1 = 3'd0; bus.req_a1 = '0; bus.req_b1 = '0;
    bus.rsp_ready = 1'b0;
    fork
      monitor();
    join_none

    // reset values, with both requesters asking
    #1 reset_n = 1'b0;
    #11;
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rst_rsp_id", bus.rsp_id, 1'b0);
    check_eq("rst_rsp_err", bus.rsp_err, 1'b0);
    check_eq("rst_req_ready", bus.req_ready, 2'b00);
    check_eq("rst_state", dbg_state, IDLE);
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.rsp_ready = 1'b1;

    // both requesters valid every cycle: SUB 10-5 and XOR 10^5 alternate
    begin
      int sent0, sent1;
      sent0 = 0; sent1 = 0;
      for (int k = 0; k < 80 && (sent0 < 3 || sent1 < 3 || bus.req_valid != 2'b00); k++) begin
        if (!bus.req_valid[0] && sent0 < 3) begin offer(0, OP_SUB, 8'd10, 8'd5); sent0++; end
        if (!bus.req_valid[1] && sent1 < 3) begin offer(1, OP_XOR, 8'd10, 8'd5); sent1++; end
        step();
      end
      drain();
    end

    // single-op directed cases
    offer(0, OP_ADD, 8'd10, 8'd5);  drain();
    offer(1, OP_DIV, 8'd200, 8'd7); drain();
    offer(0, OP_DIV, 8'd200, 8'd0); drain();
    offer(1, OP_MUL, 8'd20, 8'd20); drain();
    offer(0, 3'b111, 8'd9, 8'd3);   drain();
    offer(1, OP_SUB, 8'd3, 8'd9);   drain();

    // consumer stalls 5 cycles in RESP while the other requester waits
    bus.rsp_ready = 1'b0;
    offer(0, OP_OR, 8'h5A, 8'h0F);
    for (int k = 0; k < 10 && !bus.rsp_valid; k++) step();
    offer(1, OP_AND, 8'h5A, 8'h0F);
    repeat (5) step();
    bus.rsp_ready = 1'b1;
    drain();

    // reset in the middle of a division
    offer(0, OP_DIV, 8'd200, 8'd7);
    repeat (4) step();
    offer(1, OP_ADD, 8'd1, 8'd2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("mid_rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("mid_rst_rsp_id", bus.rsp_id, 1'b0);
    check_eq("mid_rst_rsp_err", bus.rsp_err, 1'b0);
    check_eq("mid_rst_req_ready", bus.req_ready, 2'b00);
    check_eq("mid_rst_state", dbg_state, IDLE);
    bus.req_valid = 2'b00;
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (14) step();

    // random traffic with a random consumer
    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
          offer(i, 3'($urandom_range(0, 7)), W'($urandom),
                ($urandom_range(0, 4) == 0) ? W'(0) : W'($urandom));
      end
      step();
    end
    rand_ready = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 SHALL have parameter: DATA_W, 8, operand/result width (>=4).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  2  per-requester command valid (bit i = requester i).
REQ-005 SHALL have port: req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 SHALL have ports: req_op0/req_op1  input  3  operation code, interpreted as operation_t.
REQ-007 SHALL have ports: req_a0/req_b0/req_a1/req_b1  input  DATA_W  operands.
REQ-008 SHALL have port: rsp_valid  output  1  result valid.
REQ-009 SHALL have port: rsp_ready  input  1  result accepted by consumer.
REQ-010 SHALL have port: rsp_id  output  1  requester index of the result.
REQ-011 SHALL have port: rsp_data  output  DATA_W  result.
REQ-012 SHALL have port: rsp_err  output  1  INVALID op or divide-by-zero.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DIVIDE, RESP; one command in flight at a time.
REQ-014 In IDLE, SHALL grant one valid requester combinationally: if only one valid, that one; if both, the one not granted last (round-robin pointer, initial favour requester 0).
REQ-015 req_ready SHALL be high only in IDLE, only for the granted requester; transfer = valid & ready; grant pointer updates on transfer only.
REQ-016 On transfer SHALL capture op, a, b, id; next state EXEC, except DIV with b!=0 -> DIVIDE.
REQ-017 EXEC SHALL last one cycle, compute result, go to RESP: ADD a+b, SUB a-b, MUL low DATA_W bits of a*b, AND, OR, XOR; all mod 2^DATA_W.
REQ-018 INVALID (3'b111) SHALL yield rsp_data 0, rsp_err 1; other non-DIV ops rsp_err 0.
REQ-019 DIV with b==0 SHALL go EXEC, yield rsp_data all ones, rsp_err 1.
REQ-020 DIVIDE SHALL run a restoring shift-subtract divider, exactly DATA_W cycles via counter, unsigned quotient, then RESP with rsp_err 0.
REQ-021 Latency (transfer cycle N): rsp_valid first high cycle N+2 for non-DIV / div-by-zero, N+2+DATA_W-1 = N+DATA_W+1 for DIV.
REQ-022 In RESP, rsp_valid SHALL be high; rsp_data/rsp_id/rsp_err registered and stable until rsp_ready sampled high, then IDLE.
REQ-023 No new command SHALL be accepted in the cycle rsp handshake completes; earliest next transfer is the following IDLE cycle.
REQ-024 Requester holding req_valid while not granted SHALL not be dropped; starvation bounded to one command.

Reset
REQ-025 On reset_n low, immediately: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, req_ready 0, grant pointer favours requester 0, divider counter 0.
REQ-026 Reset mid-EXEC/DIVIDE/RESP SHALL abort the command with no result emitted.

Structure
REQ-027 operation_t (ADD=000,SUB=001,MUL=010,DIV=011,AND=100,OR=101,XOR=110,INVALID=111) SHALL come from operation_pkg; scheduler state enum SHALL be added there as sched_state_t.
REQ-028 Divider SHALL be a sub-module seq_divider (start, busy/done, quotient) instantiated once.

Verification
REQ-029 Req0 ADD a=10 b=5, rsp_ready=1 -> rsp_valid at N+2, data 15, id 0, err 0.
REQ-030 Both valid every cycle, SUB 10-5 and XOR 10^5 -> grants alternate 0,1,0; data 5 and 15 interleaved.
REQ-031 DIV a=200 b=7 (DATA_W=8) -> rsp_valid at N+9, data 28, err 0; DIV b=0 -> data 8'hFF, err 1.
REQ-032 MUL a=20 b=20 -> data 8'h90; op 3'b111 -> data 0, err 1.
REQ-033 rsp_ready held 0 for 5 cycles in RESP -> rsp outputs stable, req_ready both 0 throughout.
REQ-034 reset_n pulsed low mid-DIVIDE -> all outputs 0 asynchronously, no rsp_valid afterward until new command.
